usb_tx_encoder: RTL



---
 rtl/usb_tx_pkg.sv | 26 ++
 rtl/usb_tx_encoder.sv | 137 +++++++++++++
 2 files changed

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit encoder.
package usb_tx_pkg;

    // Encoder sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_STUFF,
        ST_EOP_SE0,
        ST_EOP_J
    } tx_enc_state_t;

    // Line states as {d_plus, d_minus}.
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam int DEF_STUFF_LIMIT  = 6;
    localparam int DEF_EOP_SE0_BITS = 2;

    // NRZI transition for a transmitted 0: J <-> K.
    function automatic logic [1:0] nrzi_toggle(input logic [1:0] line);
        return (line == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/usb_tx_encoder.sv
// USB transmit encoder: paces the shift register, inserts stuffed zeros,
// NRZI-encodes the bit stream and frames the packet with SE0,SE0,J.
module usb_tx_encoder
    import usb_tx_pkg::*;
#(
    parameter int STUFF_LIMIT  = DEF_STUFF_LIMIT,
    parameter int EOP_SE0_BITS = DEF_EOP_SE0_BITS
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_strobe,
    input  logic tx_start,
    input  logic serial_in,
    input  logic eop_req,
    output logic shift_enable,
    output logic d_plus,
    output logic d_minus,
    output logic busy,
    output logic eop_done
);

    localparam int OW = $clog2(STUFF_LIMIT + 1);
    localparam int EW = $clog2(EOP_SE0_BITS + 1);

    tx_enc_state_t state_q, state_d;
    logic [OW-1:0] ones_q, ones_d, ones_inc;
    logic [EW-1:0] se0_q, se0_d;
    logic [1:0]    line_q, line_d;
    logic          shift_d, done_d, busy_d;

    assign ones_inc = ones_q + OW'(1);

    // State and registered outputs; reset parks the line at J with no EOP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ones_q       <= '0;
            se0_q        <= '0;
            line_q       <= LINE_J;
            shift_enable <= 1'b0;
            eop_done     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            ones_q       <= ones_d;
            se0_q        <= se0_d;
            line_q       <= line_d;
            shift_enable <= shift_d;
            eop_done     <= done_d;
            busy         <= busy_d;
        end
    end

    // Next-state and next-output decode, evaluated per bit strobe.
    always_comb begin
        state_d = state_q;
        ones_d  = ones_q;
        se0_d   = se0_q;
        line_d  = line_q;
        shift_d = 1'b0;
        done_d  = 1'b0;
        busy_d  = busy_q_hold();
        case (state_q)
            ST_IDLE: begin
                line_d = LINE_J;
                busy_d = 1'b0;
                se0_d  = '0;
                // A strobe coinciding with tx_start is not a data bit.
                if (tx_start) begin
                    state_d = ST_DATA;
                    ones_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_strobe) begin
                    if (eop_req) begin
                        // First SE0 bit time; serial_in is left unconsumed.
                        line_d  = LINE_SE0;
                        se0_d   = EW'(1);
                        state_d = ST_EOP_SE0;
                    end else begin
                        shift_d = 1'b1;
                        if (serial_in) begin
                            ones_d = ones_inc;
                            if (ones_inc == OW'(STUFF_LIMIT))
                                state_d = ST_STUFF;
                        end else begin
                            line_d = nrzi_toggle(line_q);
                            ones_d = '0;
                        end
                    end
                end
            end
            ST_STUFF: begin
                // Stuffed zero wins over a pending eop_req.
                if (bit_strobe) begin
                    line_d  = nrzi_toggle(line_q);
                    ones_d  = '0;
                    state_d = ST_DATA;
                end
            end
            ST_EOP_SE0: begin
                if (bit_strobe) begin
                    if (se0_q == EW'(EOP_SE0_BITS)) begin
                        line_d  = LINE_J;
                        state_d = ST_EOP_J;
                    end else begin
                        se0_d = se0_q + EW'(1);
                    end
                end
            end
            ST_EOP_J: begin
                if (bit_strobe) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    se0_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                line_d  = LINE_J;
                busy_d  = 1'b0;
            end
        endcase
    end

    // busy holds its value unless a state transition above changes it.
    function automatic logic busy_q_hold();
        return busy;
    endfunction

    assign d_plus  = line_q[1];
    assign d_minus = line_q[0];

endmodule
